// File: rtl/mult_pkg.sv
// Shared types and widths for the multiply-accumulate block.
package mult_pkg;

    typedef enum logic {
        ACC,
        DONE
    } state_t;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned PROD_W = 4;

endpackage

// File: rtl/Multiplier_2.sv
// Combinational 2x2 unsigned multiplier producing a 4-bit product.
module Multiplier_2
    import mult_pkg::*;
(
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    output logic [PROD_W-1:0] z
);

    assign z = PROD_W'(x) * PROD_W'(y);

endmodule

// File: rtl/mult_accumulator.sv
// Frame-based multiply-accumulate with valid/ready on both sides.
// Define MULT_ACC_SAT_EN to saturate on overflow instead of wrapping.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned ACC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_x,
    input  logic [OP_W-1:0]   in_y,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic               started_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic [ACC_W-1:0]   acc_add;
    logic               ovf_add;
    logic               accept;

    Multiplier_2 u_mult (
        .x (in_x),
        .y (in_y),
        .z (prod)
    );

    assign sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry   = sum[ACC_W];
    assign ovf_add = ovf_q | carry;

`ifdef MULT_ACC_SAT_EN
    assign acc_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    // started_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = started_q && (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    if (in_last) begin
                        out_data_d = acc_add;
                        out_ovf_d  = ovf_add;
                        state_d    = DONE;
                    end else begin
                        acc_d = acc_add;
                        ovf_d = ovf_add;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            started_q  <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            started_q  <= 1'b1;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench for mult_accumulator: directed vectors plus random frames.
module tb_mult_accumulator;

    localparam int unsigned ACC_W = 8;
    localparam int unsigned MAX_V = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_x = '0;
    logic [1:0]       in_y = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] n;
        logic [7:0] xs;
        logic [7:0] ys;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[5];

    mult_accumulator #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [1:0] x, input logic [1:0] y, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_last  = last;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Expects the result one cycle after the last beat, optionally stalls, then consumes.
    task automatic take_result(input string name, input logic [31:0] exp_data,
                               input logic exp_ovf, input int hold, input bit drive_in);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, 32'(out_data), exp_data);
        check({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        if (drive_in) begin
            in_valid = 1'b1;
            in_x     = 2'd3;
            in_y     = 2'd3;
            in_last  = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_data"}, 32'(out_data), exp_data);
            check({name, "_hold_ovf"}, 32'(out_ovf), 32'(exp_ovf));
            check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_ready_back"}, 32'(in_ready), 32'd1);
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{n: 3'd1, xs: 8'h03, ys: 8'h03, exp_data: 8'd9, exp_ovf: 1'b0};
        vecs[1] = '{n: 3'd4, xs: {2'd3, 2'd3, 2'd2, 2'd1}, ys: {2'd3, 2'd2, 2'd3, 2'd1},
                    exp_data: 8'd22, exp_ovf: 1'b0};
        vecs[2] = '{n: 3'd4, xs: {2'd2, 2'd0, 2'd3, 2'd0}, ys: {2'd1, 2'd0, 2'd0, 2'd3},
                    exp_data: 8'd2, exp_ovf: 1'b0};
        vecs[3] = '{n: 3'd4, xs: 8'hff, ys: 8'hff, exp_data: 8'd36, exp_ovf: 1'b0};
        vecs[4] = '{n: 3'd2, xs: {4'd0, 2'd2, 2'd1}, ys: {4'd0, 2'd1, 2'd2},
                    exp_data: 8'd4, exp_ovf: 1'b0};

        // Reset behaviour
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_before_edge_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rel_first_edge_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < int'(vecs[v].n); b++) begin
                send_beat(vecs[v].xs[2*b +: 2], vecs[v].ys[2*b +: 2], b == int'(vecs[v].n) - 1);
            end
            take_result($sformatf("vec%0d", v), 32'(vecs[v].exp_data), vecs[v].exp_ovf, 0, 1'b0);
        end

        // Overflow: 29 x 9 = 261
        for (int i = 0; i < 29; i++) send_beat(2'd3, 2'd3, i == 28);
`ifdef MULT_ACC_SAT_EN
        take_result("ovf29", 32'd255, 1'b1, 0, 1'b0);
`else
        take_result("ovf29", 32'd5, 1'b1, 0, 1'b0);
`endif

        // Backpressure with in_valid held high in DONE; the next frame must start clean
        send_beat(2'd2, 2'd3, 1'b0);
        send_beat(2'd1, 2'd1, 1'b1);
        take_result("bp", 32'd7, 1'b0, 5, 1'b1);
        send_beat(2'd1, 2'd1, 1'b1);
        take_result("bp_next", 32'd1, 1'b0, 0, 1'b0);

        // Reset mid-frame discards the partial sum
        send_beat(2'd3, 2'd3, 1'b0);
        send_beat(2'd2, 2'd2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", 32'(in_ready), 32'd1);
        send_beat(2'd1, 2'd2, 1'b1);
        take_result("midrst", 32'd2, 1'b0, 0, 1'b0);

        // Back-to-back frames with out_ready held high
        out_ready = 1'b1;
        send_beat(2'd2, 2'd2, 1'b1);
        @(negedge clk);
        check("b2b_a_valid", 32'(out_valid), 32'd1);
        check("b2b_a_data", 32'(out_data), 32'd4);
        check("b2b_a_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("b2b_a_ready_back", 32'(in_ready), 32'd1);
        check("b2b_a_valid_drop", 32'(out_valid), 32'd0);
        send_beat(2'd3, 2'd1, 1'b1);
        @(negedge clk);
        check("b2b_b_valid", 32'(out_valid), 32'd1);
        check("b2b_b_data", 32'(out_data), 32'd3);
        check("b2b_b_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("b2b_b_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Random frames against an arithmetic reference
        for (int f = 0; f < 30; f++) begin
            int n;
            int total;
            logic [31:0] exp_data;
            logic exp_ovf;
            logic [1:0] x, y;
            n = int'($urandom_range(40, 1));
            total = 0;
            for (int b = 0; b < n; b++) begin
                x = 2'($urandom_range(3, 0));
                y = 2'($urandom_range(3, 0));
                total += int'(x) * int'(y);
                send_beat(x, y, b == n - 1);
            end
            exp_ovf = (total > int'(MAX_V));
`ifdef MULT_ACC_SAT_EN
            exp_data = exp_ovf ? 32'(MAX_V) : 32'(total);
`else
            exp_data = 32'(total % (int'(MAX_V) + 1));
`endif
            take_result($sformatf("rand%0d", f), exp_data, exp_ovf,
                        int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
